// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Bundles the three buses around the memory arbiter.
//               ibus (fetch), dbus (data) and cbus (shared memory bus),
//               plus the sticky watchdog flag.
//               slave  - arbiter side: takes ibus/dbus requests and cbus
//                        responses; drives the responses and cbus requests.
//               master - environment side (core + memory), the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
    // ibus
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    // dbus
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    // cbus
    logic        creq_valid;
    logic        creq_is_write;
    logic [2:0]  creq_size;
    logic [63:0] creq_addr;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ready;
    logic        cresp_last;
    logic [63:0] cresp_data;
    // watchdog
    logic        timeout_err;

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        output creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe, creq_data,
        input  cresp_ready, cresp_last, cresp_data,
        output timeout_err
    );

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        input  creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe, creq_data,
        output cresp_ready, cresp_last, cresp_data,
        input  timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory bus (cbus) between the instruction port
//               (ibus) and data port (dbus). One transaction outstanding at a
//               time: the winning request is latched, driven on cbus from
//               registers, and the single-beat response is routed back to
//               the owner combinationally. A watchdog raises a sticky
//               timeout_err if a transaction stays open too long.
// Ports       : clk   - clock
//               reset - synchronous active-high reset
//               bus   - mem_bus_arbiter_if.slave (ibus, dbus, cbus, timeout_err)
// Parameters  : TIMEOUT - BUSY cycles without cresp_last before timeout_err
//                         (0 disables the watchdog)
//               CNT_W   - watchdog counter width (TIMEOUT < 2**CNT_W)
// Options     : RR_ARB_EN - defined: round-robin on ties;
//                           undefined: fixed priority, dbus wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mem_bus_arbiter_if.slave    bus
);
    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_BUSY = 1'b1;
    localparam logic       C_OWN_I   = 1'b0;
    localparam logic       C_OWN_D   = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             creq_valid_q, creq_valid_d;
    logic             creq_is_write_q, creq_is_write_d;
    logic [2:0]       creq_size_q, creq_size_d;
    logic [63:0]      creq_addr_q, creq_addr_d;
    logic [7:0]       creq_strobe_q, creq_strobe_d;
    logic [63:0]      creq_data_q, creq_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`ifdef RR_ARB_EN
    // Port granted most recently; reset to I so that D wins the first tie.
    logic             last_q, last_d;
`endif

    logic w_grant;
    logic w_done;

    // Arbitration: only consulted in IDLE
    always_comb begin
`ifdef RR_ARB_EN
        if (bus.ireq_valid && bus.dreq_valid) begin
            w_grant = ~last_q;
        end else begin
            w_grant = bus.dreq_valid ? C_OWN_D : C_OWN_I;
        end
`else
        w_grant = bus.dreq_valid ? C_OWN_D : C_OWN_I;
`endif
    end

    assign w_done = (state_q == C_ST_BUSY) && bus.cresp_ready && bus.cresp_last;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        creq_valid_d    = creq_valid_q;
        creq_is_write_d = creq_is_write_q;
        creq_size_d     = creq_size_q;
        creq_addr_d     = creq_addr_q;
        creq_strobe_d   = creq_strobe_q;
        creq_data_d     = creq_data_q;
        cnt_d           = cnt_q;
        timeout_d       = timeout_q;
`ifdef RR_ARB_EN
        last_d          = last_q;
`endif
        case (state_q)
            C_ST_IDLE: begin
                if (bus.ireq_valid || bus.dreq_valid) begin
                    state_d      = C_ST_BUSY;
                    owner_d      = w_grant;
                    creq_valid_d = 1'b1;
                    cnt_d        = '0;
`ifdef RR_ARB_EN
                    last_d       = w_grant;
`endif
                    if (w_grant == C_OWN_D) begin
                        creq_is_write_d = |bus.dreq_strobe;
                        creq_size_d     = bus.dreq_size;
                        creq_addr_d     = bus.dreq_addr;
                        creq_strobe_d   = bus.dreq_strobe;
                        creq_data_d     = bus.dreq_data;
                    end else begin
                        // Fetches are always 4-byte reads
                        creq_is_write_d = 1'b0;
                        creq_size_d     = 3'd2;
                        creq_addr_d     = bus.ireq_addr;
                        creq_strobe_d   = 8'h00;
                        creq_data_d     = 64'h0;
                    end
                end
            end
            default: begin
                if (w_done) begin
                    state_d      = C_ST_IDLE;
                    creq_valid_d = 1'b0;
                end
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT)) && !w_done) begin
                    timeout_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= C_ST_IDLE;
            owner_q         <= C_OWN_I;
            creq_valid_q    <= 1'b0;
            creq_is_write_q <= 1'b0;
            creq_size_q     <= 3'd0;
            creq_addr_q     <= 64'h0;
            creq_strobe_q   <= 8'h00;
            creq_data_q     <= 64'h0;
            cnt_q           <= '0;
            timeout_q       <= 1'b0;
`ifdef RR_ARB_EN
            last_q          <= C_OWN_I;
`endif
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            creq_valid_q    <= creq_valid_d;
            creq_is_write_q <= creq_is_write_d;
            creq_size_q     <= creq_size_d;
            creq_addr_q     <= creq_addr_d;
            creq_strobe_q   <= creq_strobe_d;
            creq_data_q     <= creq_data_d;
            cnt_q           <= cnt_d;
            timeout_q       <= timeout_d;
`ifdef RR_ARB_EN
            last_q          <= last_d;
`endif
        end
    end

    // Responses are combinational from cresp; data is zeroed when not valid
    // so that idle/reset outputs stay at 0.
    assign bus.iresp_data_ok = w_done && (owner_q == C_OWN_I);
    assign bus.iresp_addr_ok = bus.iresp_data_ok;
    assign bus.iresp_data    = !bus.iresp_data_ok ? 32'h0 :
                               (creq_addr_q[2] ? bus.cresp_data[63:32] : bus.cresp_data[31:0]);
    assign bus.dresp_data_ok = w_done && (owner_q == C_OWN_D);
    assign bus.dresp_addr_ok = bus.dresp_data_ok;
    assign bus.dresp_data    = bus.dresp_data_ok ? bus.cresp_data : 64'h0;

    assign bus.creq_valid    = creq_valid_q;
    assign bus.creq_is_write = creq_is_write_q;
    assign bus.creq_size     = creq_size_q;
    assign bus.creq_addr     = creq_addr_q;
    assign bus.creq_strobe   = creq_strobe_q;
    assign bus.creq_data     = creq_data_q;
    assign bus.timeout_err   = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed self-checking bench for mem_bus_arbiter (TIMEOUT=8).
//               Memory responses are driven by hand, one step per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cresp_set(input logic rdy, input logic lst, input logic [63:0] d);
        bus.cresp_ready = rdy;
        bus.cresp_last  = lst;
        bus.cresp_data  = d;
    endtask

    // One tied transaction: both ports valid in the current IDLE cycle
    task automatic tie_txn(input string tag, input logic exp_d);
        tick;
        check({tag, "_addr"}, bus.creq_addr, exp_d ? 64'h2000 : 64'h1000);
        cresp_set(1'b1, 1'b1, 64'hCAFE_0000_0000_BEEF);
        #1;
        check({tag, "_iok"}, {63'h0, bus.iresp_data_ok}, {63'h0, ~exp_d});
        check({tag, "_dok"}, {63'h0, bus.dresp_data_ok}, {63'h0, exp_d});
        tick;
        cresp_set(1'b0, 1'b0, 64'h0);
        #1;
        check({tag, "_idle"}, {63'h0, bus.creq_valid}, 64'h0);
    endtask

    logic exp_tie2;

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef RR_ARB_EN
        exp_tie2 = 1'b0;
`else
        exp_tie2 = 1'b1;
`endif
        reset           = 1'b1;
        bus.ireq_valid  = 1'b0;
        bus.ireq_addr   = 64'h0;
        bus.dreq_valid  = 1'b0;
        bus.dreq_addr   = 64'h0;
        bus.dreq_size   = 3'd0;
        bus.dreq_strobe = 8'h00;
        bus.dreq_data   = 64'h0;
        cresp_set(1'b0, 1'b0, 64'h0);
        tick;
        tick;
        check("rst_creq_valid", {63'h0, bus.creq_valid}, 64'h0);
        check("rst_timeout", {63'h0, bus.timeout_err}, 64'h0);
        check("rst_iok", {63'h0, bus.iresp_data_ok}, 64'h0);
        check("rst_dok", {63'h0, bus.dresp_data_ok}, 64'h0);
        reset = 1'b0;
        tick;

        // ---- Lone fetch ----
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h8000_0004;
        #1;
        check("fetch_c0_valid", {63'h0, bus.creq_valid}, 64'h0);
        tick;
        check("fetch_valid", {63'h0, bus.creq_valid}, 64'h1);
        check("fetch_size", {61'h0, bus.creq_size}, 64'd2);
        check("fetch_strobe", {56'h0, bus.creq_strobe}, 64'h0);
        check("fetch_wr", {63'h0, bus.creq_is_write}, 64'h0);
        check("fetch_addr", bus.creq_addr, 64'h8000_0004);
        tick;
        cresp_set(1'b1, 1'b0, 64'h1234);   // ready without last: ignored
        #1;
        check("fetch_nolast_ok", {63'h0, bus.iresp_data_ok}, 64'h0);
        tick;
        cresp_set(1'b0, 1'b0, 64'h0);
        tick;
        cresp_set(1'b1, 1'b1, 64'h1122_3344_5566_7788);
        #1;
        check("fetch_dok", {63'h0, bus.iresp_data_ok}, 64'h1);
        check("fetch_aok", {63'h0, bus.iresp_addr_ok}, 64'h1);
        check("fetch_data", {32'h0, bus.iresp_data}, 64'h1122_3344);
        check("fetch_d_dok", {63'h0, bus.dresp_data_ok}, 64'h0);
        tick;
        bus.ireq_valid = 1'b0;
        cresp_set(1'b0, 1'b0, 64'h0);
        #1;
        check("fetch_after_valid", {63'h0, bus.creq_valid}, 64'h0);
        check("fetch_after_dok", {63'h0, bus.iresp_data_ok}, 64'h0);
        tick;

        // ---- Lone store ----
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h100;
        bus.dreq_size   = 3'd3;
        bus.dreq_strobe = 8'h0F;
        bus.dreq_data   = 64'hAB;
        tick;
        check("store_wr", {63'h0, bus.creq_is_write}, 64'h1);
        check("store_addr", bus.creq_addr, 64'h100);
        check("store_strobe", {56'h0, bus.creq_strobe}, 64'h0F);
        check("store_data", bus.creq_data, 64'hAB);
        check("store_size", {61'h0, bus.creq_size}, 64'd3);
        tick;
        cresp_set(1'b1, 1'b1, 64'h0);
        #1;
        check("store_dok", {63'h0, bus.dresp_data_ok}, 64'h1);
        check("store_aok", {63'h0, bus.dresp_addr_ok}, 64'h1);
        check("store_i_dok", {63'h0, bus.iresp_data_ok}, 64'h0);
        tick;
        bus.dreq_valid = 1'b0;
        cresp_set(1'b0, 1'b0, 64'h0);
        #1;
        check("store_idle", {63'h0, bus.creq_valid}, 64'h0);

        // ---- Three tied transactions from a fresh reset ----
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus.ireq_valid  = 1'b1;
        bus.ireq_addr   = 64'h1000;
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h2000;
        bus.dreq_strobe = 8'h00;
        bus.dreq_size   = 3'd3;
        tie_txn("tie1", 1'b1);
        tie_txn("tie2", exp_tie2);
        tie_txn("tie3", 1'b1);
        bus.ireq_valid = 1'b0;
        bus.dreq_valid = 1'b0;
        tick;
        tick;

        // ---- Input change mid-BUSY, dreq waits, idle cresp ignored ----
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h40;
        tick;
        bus.ireq_addr  = 64'h80;
        bus.dreq_valid = 1'b1;
        bus.dreq_addr  = 64'h3000;
        tick;
        check("chg_addr_held", bus.creq_addr, 64'h40);
        cresp_set(1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
        #1;
        check("chg_iok", {63'h0, bus.iresp_data_ok}, 64'h1);
        check("chg_idata_low", {32'h0, bus.iresp_data}, 64'hCCCC_DDDD);
        check("chg_d_waits", {63'h0, bus.dresp_data_ok}, 64'h0);
        tick;
        bus.ireq_valid = 1'b0;
        #1;
        check("idle_cresp_iok", {63'h0, bus.iresp_data_ok}, 64'h0);
        check("idle_cresp_dok", {63'h0, bus.dresp_data_ok}, 64'h0);
        tick;
        cresp_set(1'b0, 1'b0, 64'h0);
        #1;
        check("pend_d_addr", bus.creq_addr, 64'h3000);
        tick;
        cresp_set(1'b1, 1'b1, 64'h55);
        #1;
        check("pend_d_dok", {63'h0, bus.dresp_data_ok}, 64'h1);
        check("pend_d_data", bus.dresp_data, 64'h55);
        tick;
        bus.dreq_valid = 1'b0;
        cresp_set(1'b0, 1'b0, 64'h0);
        tick;

        // ---- Watchdog (TIMEOUT=8) ----
        bus.dreq_valid = 1'b1;
        bus.dreq_addr  = 64'h300;
        tick;                                  // BUSY cycle 1
        for (int i = 0; i < 7; i++) tick;      // BUSY cycle 8
        check("wd_not_yet", {63'h0, bus.timeout_err}, 64'h0);
        for (int i = 0; i < 4; i++) tick;      // BUSY cycle 12
        check("wd_set", {63'h0, bus.timeout_err}, 64'h1);
        check("wd_still_busy", {63'h0, bus.creq_valid}, 64'h1);
        cresp_set(1'b1, 1'b1, 64'h77);
        #1;
        check("wd_late_dok", {63'h0, bus.dresp_data_ok}, 64'h1);
        tick;
        bus.dreq_valid = 1'b0;
        cresp_set(1'b0, 1'b0, 64'h0);
        #1;
        check("wd_sticky", {63'h0, bus.timeout_err}, 64'h1);
        check("wd_idle", {63'h0, bus.creq_valid}, 64'h0);

        // ---- Reset mid-BUSY ----
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h500;
        tick;
        check("rb_busy", {63'h0, bus.creq_valid}, 64'h1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus.ireq_valid = 1'b0;
        #1;
        check("rb_valid", {63'h0, bus.creq_valid}, 64'h0);
        check("rb_timeout", {63'h0, bus.timeout_err}, 64'h0);
        cresp_set(1'b1, 1'b1, 64'h99);
        #1;
        check("rb_late_iok", {63'h0, bus.iresp_data_ok}, 64'h0);
        check("rb_late_dok", {63'h0, bus.dresp_data_ok}, 64'h0);
        tick;
        cresp_set(1'b0, 1'b0, 64'h0);
        #1;
        check("rb_stay_idle", {63'h0, bus.creq_valid}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
